// File: rtl/clb_cfg_pkg.sv
// Shared configuration helpers for the CLB routing-mux bank.
// Covers chain sizing and the per-mux output mode encoding.
package clb_cfg_pkg;

  typedef enum logic {
    MODE_COMB = 1'b0,
    MODE_REG  = 1'b1
  } mode_e;

  function automatic int unsigned calc_cw(input int unsigned width);
    return int'($clog2(width)) + 1;
  endfunction

  function automatic int unsigned calc_cfg_bits(input int unsigned width,
                                                input int unsigned num_mux);
    return num_mux * calc_cw(width);
  endfunction

endpackage

// File: rtl/cfg_mux_array_predecode.sv
// Select-index to one-hot predecoder.
// Indices at or above WIDTH decode to all-zero so the mux drives 0.
module onehot_predecode #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = $clog2(WIDTH)
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [WIDTH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx == ADDR_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cfg_mux_array.sv
// Bank of serially configured, predecoded routing muxes.
// Each mux has a combinational or registered output mode.
module cfg_mux_array
  import clb_cfg_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NUM_MUX  = 2,
  parameter int unsigned ADDR_W   = $clog2(WIDTH),
  parameter int unsigned CW       = calc_cw(WIDTH),
  parameter int unsigned CFG_BITS = calc_cfg_bits(WIDTH, NUM_MUX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_MUX*WIDTH-1:0]   data,
  input  logic                       cfg_en,
  input  logic                       cfg_in,
  input  logic                       cfg_load,
  output logic                       cfg_out,
  output logic                       cfg_done,
  output logic [NUM_MUX-1:0]         out
);

  logic [CFG_BITS-1:0]             chain;
  logic [NUM_MUX-1:0][WIDTH-1:0]   dec;
  logic [NUM_MUX-1:0][WIDTH-1:0]   onehot;
  logic [NUM_MUX-1:0]              mode;
  logic [NUM_MUX-1:0]              flop;
  logic [NUM_MUX-1:0]              sel_val;
  logic                            done;

  // Predecode straight off the chain so the commit edge only copies flops.
  for (genvar k = 0; k < NUM_MUX; k++) begin : g_dec
    onehot_predecode #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_dec (
      .idx    (chain[k*CW +: ADDR_W]),
      .onehot (dec[k])
    );
  end

  always_comb begin
    sel_val = '0;
    out     = '0;
    for (int unsigned k = 0; k < NUM_MUX; k++) begin
      sel_val[k] = |(onehot[k] & data[k*WIDTH +: WIDTH]);
      out[k]     = (mode[k] == MODE_REG) ? flop[k] : sel_val[k];
    end
  end

  // Commit and shift both read the pre-edge chain when asserted together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      onehot <= '0;
      mode   <= '0;
      flop   <= '0;
      done   <= 1'b0;
    end else begin
      flop <= sel_val;
      if (cfg_en) chain <= {cfg_in, chain[CFG_BITS-1:1]};
      if (cfg_load) begin
        onehot <= dec;
        done   <= 1'b1;
        for (int unsigned k = 0; k < NUM_MUX; k++) begin
          mode[k] <= chain[k*CW + ADDR_W];
        end
      end
    end
  end

  assign cfg_out  = chain[0];
  assign cfg_done = done;

endmodule

// File: tb/tb_cfg_mux_array.sv
// Self-checking bench for cfg_mux_array: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cfg_mux_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       cfg_en, cfg_in, cfg_load;
  logic       cfg_out, cfg_done;
  logic [1:0] out;

  logic [5:0] data3;
  logic       cfg_en3, cfg_in3, cfg_load3;
  logic       cfg_out3, cfg_done3;
  logic [1:0] out3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cfg_mux_array #(.WIDTH(4), .NUM_MUX(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_load(cfg_load), .cfg_out(cfg_out), .cfg_done(cfg_done), .out(out)
  );

  cfg_mux_array #(.WIDTH(3), .NUM_MUX(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data(data3), .cfg_en(cfg_en3), .cfg_in(cfg_in3),
    .cfg_load(cfg_load3), .cfg_out(cfg_out3), .cfg_done(cfg_done3), .out(out3)
  );

  // Reference model for the WIDTH=4 instance: chain is a bit queue, index 0 = LSB.
  bit m_chain[$];
  int m_sel[2];
  bit m_mode[2];
  bit m_flop[2];
  bit m_done;

  function automatic void model_reset();
    m_chain = {};
    for (int i = 0; i < 6; i++) m_chain.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = -1;
      m_mode[k] = 1'b0;
      m_flop[k] = 1'b0;
    end
    m_done = 1'b0;
  endfunction

  function automatic bit model_selv(int k, logic [7:0] d);
    if (m_sel[k] < 0 || m_sel[k] >= 4) return 1'b0;
    return d[k*4 + m_sel[k]];
  endfunction

  function automatic logic [1:0] model_out(logic [7:0] d);
    logic [1:0] r;
    for (int k = 0; k < 2; k++) r[k] = m_mode[k] ? m_flop[k] : model_selv(k, d);
    return r;
  endfunction

  function automatic void model_edge(bit en, bit din, bit load, logic [7:0] d);
    for (int k = 0; k < 2; k++) m_flop[k] = model_selv(k, d);
    if (load) begin
      for (int k = 0; k < 2; k++) begin
        m_sel[k]  = int'(m_chain[k*3]) + 2 * int'(m_chain[k*3+1]);
        m_mode[k] = m_chain[k*3+2];
      end
      m_done = 1'b1;
    end
    if (en) begin
      void'(m_chain.pop_front());
      m_chain.push_back(din);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},      32'(out),      32'(model_out(data)));
    check({tag, ".cfg_out"},  32'(cfg_out),  32'(m_chain[0]));
    check({tag, ".cfg_done"}, 32'(cfg_done), 32'(m_done));
  endtask

  task automatic tick();
    bit en, din, load;
    logic [7:0] d;
    en = cfg_en; din = cfg_in; load = cfg_load; d = data;
    @(posedge clk);
    if (rst_n) model_edge(en, din, load, d);
    #1;
  endtask

  task automatic send_frame(input logic [5:0] f);
    for (int i = 0; i < 6; i++) begin
      cfg_en = 1'b1; cfg_in = f[i];
      tick();
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic load_pulse();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       exp0;
    logic       exp1_next;
  } vec_t;

  vec_t vecs[5];
  logic [5:0] shadow_frame;
  logic       exp_bit;

  initial begin
    // Frame 6'b101_010: mux0 sel 2 comb, mux1 sel 1 registered.
    vecs[0] = '{8'b0000_0100, 1'b1, 1'b0};
    vecs[1] = '{8'b0010_0000, 1'b0, 1'b1};
    vecs[2] = '{8'b0010_1011, 1'b0, 1'b1};
    vecs[3] = '{8'b1101_1111, 1'b1, 1'b0};
    vecs[4] = '{8'b0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; data = 8'($urandom); cfg_en = 0; cfg_in = 0; cfg_load = 0;
    data3 = '0; cfg_en3 = 0; cfg_in3 = 0; cfg_load3 = 0;
    model_reset();
    #12;
    check("rst.out", 32'(out), 32'd0);
    check("rst.cfg_out", 32'(cfg_out), 32'd0);
    check("rst.cfg_done", 32'(cfg_done), 32'd0);
    data = 8'hFF;
    #1 check("rst.out_ff", 32'(out), 32'd0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 8'($urandom);
      tick();
      check("post_rst.out", 32'(out), 32'd0);
    end

    send_frame(6'b101_010);
    load_pulse();
    check("commit.cfg_done", 32'(cfg_done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      data = vecs[i].d;
      #1 check($sformatf("vec%0d.out0", i), 32'(out[0]), 32'(vecs[i].exp0));
      tick();
      check($sformatf("vec%0d.out1", i), 32'(out[1]), 32'(vecs[i].exp1_next));
      check_model($sformatf("vec%0d", i));
    end

    data = 8'b0000_0000; tick();
    data[5] = 1'b1;
    #1 check("toggle.before", 32'(out[1]), 32'd0);
    tick();
    check("toggle.after", 32'(out[1]), 32'd1);
    data[5] = 1'b0;
    #1 check("toggle.hold", 32'(out[1]), 32'd1);
    tick();
    check("toggle.fall", 32'(out[1]), 32'd0);

    // Shadowing: shifting a new frame leaves outputs alone; old frame drains out.
    data = 8'b0010_0100; tick();
    shadow_frame = 6'b000_011;
    for (int i = 0; i < 6; i++) begin
      exp_bit = 1'(i % 2);
      check($sformatf("shadow.cfg_out%0d", i), 32'(cfg_out), 32'(exp_bit));
      check("shadow.out", 32'(out), 32'b11);
      cfg_en = 1'b1; cfg_in = shadow_frame[i];
      tick();
    end
    cfg_en = 1'b0;
    check("shadow.out_end", 32'(out), 32'b11);

    // Simultaneous shift and commit.
    send_frame(6'b000_001);
    cfg_en = 1'b1; cfg_in = 1'b1; cfg_load = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_in = 1'b0; cfg_load = 1'b0;
    data = 8'b0000_0010;
    #1 check("simul.sel1_hi", 32'(out[0]), 32'd1);
    data = 8'b1111_1101;
    #1 check("simul.sel1_lo", 32'(out[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      exp_bit = (i == 5);
      check($sformatf("simul.chain%0d", i), 32'(cfg_out), 32'(exp_bit));
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;

    // Out-of-range select on the WIDTH=3 instance: frame 6'b010_011.
    shadow_frame = 6'b010_011;
    for (int i = 0; i < 6; i++) begin
      cfg_en3 = 1'b1; cfg_in3 = shadow_frame[i];
      tick();
    end
    cfg_en3 = 1'b0; cfg_load3 = 1'b1;
    tick();
    cfg_load3 = 1'b0;
    data3 = 6'b111_111;
    #1 check("oor.out3", 32'(out3), 32'b10);
    check("oor.done3", 32'(cfg_done3), 32'd1);
    data3 = 6'b011_111;
    #1 check("oor.out3_b", 32'(out3), 32'b00);

    // Async reset in the middle of a frame, away from any clock edge.
    send_frame(6'b000_001);
    load_pulse();
    data = 8'hFF;
    #1 check("pre_rst.out", 32'(out), 32'b11);
    shadow_frame = 6'b111_111;
    for (int i = 0; i < 3; i++) begin
      cfg_en = 1'b1; cfg_in = shadow_frame[i];
      tick();
    end
    cfg_en = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.out", 32'(out), 32'd0);
    check("midrst.cfg_out", 32'(cfg_out), 32'd0);
    check("midrst.cfg_done", 32'(cfg_done), 32'd0);
    check("midrst.out3", 32'(out3), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    send_frame(6'b111_011);
    load_pulse();
    data = 8'b1000_1000;
    #1 check_model("resume");
    check("resume.out0", 32'(out[0]), 32'd1);
    tick();
    check("resume.out1", 32'(out[1]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cfg_en   = 1'($urandom_range(0, 1));
      cfg_in   = 1'($urandom_range(0, 1));
      cfg_load = ($urandom_range(0, 7) == 0);
      data     = 8'($urandom);
      #1 check_model("rand");
      tick();
    end
    cfg_en = 1'b0; cfg_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
